// File: rtl/branch_history_ctrl_if.sv
// Fetch/execute handshake into the branch-history controller.
// The master side drives predictions and resolutions; the controller answers with pred_ready.
interface branch_history_ctrl_if;
    logic pred_valid;
    logic pred_taken;
    logic pred_ready;
    logic res_valid;
    logic res_taken;

    modport master (
        output pred_valid, pred_taken, res_valid, res_taken,
        input  pred_ready
    );

    modport slave (
        input  pred_valid, pred_taken, res_valid, res_taken,
        output pred_ready
    );
endinterface

// File: rtl/branch_history_ctrl.sv
// Speculative/committed branch-history tracker with in-order prediction FIFO.
// Detects mispredicts on resolve and restores the speculative history from the committed one.
//
// state   | meaning
// --------+---------------------------------------------------------------
// NORM    | accept predictions and resolutions
// RECOVER | single cycle after a mispredict; fetch stalled, FIFO empty
module branch_history_ctrl #(
    parameter int REGSIZE = 2,
    parameter int DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    branch_history_ctrl_if.slave       bus,
    output logic [REGSIZE-1:0]         spec_bhr,
    output logic [REGSIZE-1:0]         commit_bhr,
    output logic                       flush,
    output logic [$clog2(DEPTH):0]     inflight,
    output logic                       err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic {NORM, RECOVER} state_t;

    state_t            state;
    logic [DEPTH-1:0]  fifo_q;
    logic [AW-1:0]     head;
    logic [AW-1:0]     tail;

    logic resolve;
    logic mispredict;
    logic push;

    function automatic logic [REGSIZE-1:0] shift_in(input logic b, input logic [REGSIZE-1:0] h);
        return {b, h[REGSIZE-1:1]};
    endfunction

    assign bus.pred_ready = (state == NORM) && (inflight < DEPTH_C);

    // RECOVER always has an empty FIFO, so the inflight test alone gates resolves there
    assign resolve    = bus.res_valid && (state == NORM) && (inflight != '0);
    assign mispredict = resolve && (bus.res_taken != fifo_q[head]);
    assign push       = bus.pred_valid && bus.pred_ready && !mispredict;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= NORM;
            fifo_q     <= '0;
            head       <= '0;
            tail       <= '0;
            inflight   <= '0;
            spec_bhr   <= '0;
            commit_bhr <= '0;
            flush      <= 1'b0;
            err        <= 1'b0;
        end else begin
            flush <= 1'b0;
            if (state == RECOVER) begin
                state <= NORM;
            end

            if (bus.res_valid && (inflight == '0)) begin
                err <= 1'b1;
            end

            if (resolve) begin
                commit_bhr <= shift_in(bus.res_taken, commit_bhr);
            end

            if (mispredict) begin
                // same-cycle push is dropped: fetch is being flushed anyway
                spec_bhr <= shift_in(bus.res_taken, commit_bhr);
                head     <= '0;
                tail     <= '0;
                inflight <= '0;
                flush    <= 1'b1;
                state    <= RECOVER;
            end else begin
                if (push) begin
                    spec_bhr     <= shift_in(bus.pred_taken, spec_bhr);
                    fifo_q[tail] <= bus.pred_taken;
                    tail         <= tail + AW'(1);
                end
                if (resolve) begin
                    head <= head + AW'(1);
                end
                case ({push, resolve})
                    2'b10:   inflight <= inflight + CW'(1);
                    2'b01:   inflight <= inflight - CW'(1);
                    default: inflight <= inflight;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_branch_history_ctrl.sv
// Directed bench for branch_history_ctrl with hand-computed expectations.
module tb_branch_history_ctrl;
    logic       clk;
    logic       rstn;
    logic [1:0] spec_bhr;
    logic [1:0] commit_bhr;
    logic       flush;
    logic [2:0] inflight;
    logic       err;
    int         n_checks;
    int         n_fail;

    branch_history_ctrl_if bus();

    branch_history_ctrl #(.REGSIZE(2), .DEPTH(4)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .bus        (bus.slave),
        .spec_bhr   (spec_bhr),
        .commit_bhr (commit_bhr),
        .flush      (flush),
        .inflight   (inflight),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // drive one cycle of inputs, then sample 1 time unit after the edge
    task automatic cyc(input logic pv, input logic pt, input logic rv, input logic rt);
        bus.pred_valid = pv;
        bus.pred_taken = pt;
        bus.res_valid  = rv;
        bus.res_taken  = rt;
        @(posedge clk);
        #1;
        bus.pred_valid = 1'b0;
        bus.pred_taken = 1'b0;
        bus.res_valid  = 1'b0;
        bus.res_taken  = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #2;
        rstn = 1'b1;
    endtask

    task automatic chk_state(input string tag, input logic [1:0] s, input logic [1:0] c,
                             input logic [2:0] inf, input logic fl, input logic rdy);
        chk({tag, "_spec"},   32'(spec_bhr),       32'(s));
        chk({tag, "_commit"}, 32'(commit_bhr),     32'(c));
        chk({tag, "_inf"},    32'(inflight),       32'(inf));
        chk({tag, "_flush"},  32'(flush),          32'(fl));
        chk({tag, "_ready"},  32'(bus.pred_ready), 32'(rdy));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rstn = 1'b0;
        bus.pred_valid = 1'b0;
        bus.pred_taken = 1'b0;
        bus.res_valid  = 1'b0;
        bus.res_taken  = 1'b0;
        #1;
        chk_state("rst", 2'b00, 2'b00, 3'd0, 1'b0, 1'b1);
        chk("rst_err", 32'(err), 32'd0);
        @(posedge clk);
        #3;
        rstn = 1'b1;

        // push T, T
        cyc(1, 1, 0, 0); chk_state("p1", 2'b10, 2'b00, 3'd1, 1'b0, 1'b1);
        cyc(1, 1, 0, 0); chk_state("p2", 2'b11, 2'b00, 3'd2, 1'b0, 1'b1);

        // fill to DEPTH, overflow push ignored, then one correct resolve
        do_reset();
        cyc(1, 1, 0, 0); chk("f1_spec", 32'(spec_bhr), 32'(2'b10));
        cyc(1, 0, 0, 0); chk("f2_spec", 32'(spec_bhr), 32'(2'b01));
        cyc(1, 1, 0, 0); chk("f3_spec", 32'(spec_bhr), 32'(2'b10));
        cyc(1, 0, 0, 0); chk_state("full", 2'b01, 2'b00, 3'd4, 1'b0, 1'b0);
        cyc(1, 1, 0, 0); chk_state("ovf", 2'b01, 2'b00, 3'd4, 1'b0, 1'b0);
        cyc(0, 0, 1, 1); chk_state("res1", 2'b01, 2'b10, 3'd3, 1'b0, 1'b1);

        // build commit=11, push N,T, resolve T against predicted N
        do_reset();
        cyc(1, 1, 0, 0);
        cyc(0, 0, 1, 1); chk("c1_commit", 32'(commit_bhr), 32'(2'b10));
        cyc(1, 1, 0, 0);
        cyc(0, 0, 1, 1); chk_state("c2", 2'b11, 2'b11, 3'd0, 1'b0, 1'b1);
        cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0); chk_state("mp_pre", 2'b10, 2'b11, 3'd2, 1'b0, 1'b1);
        cyc(0, 0, 1, 1); chk_state("mp", 2'b11, 2'b11, 3'd0, 1'b1, 1'b0);
        cyc(0, 0, 0, 0); chk_state("mp_post", 2'b11, 2'b11, 3'd0, 1'b0, 1'b1);
        chk("mp_err", 32'(err), 32'd0);

        // mispredict with a simultaneous push: the push is discarded
        cyc(1, 1, 0, 0); chk("mq_pre_inf", 32'(inflight), 32'd1);
        cyc(1, 1, 1, 0); chk_state("mq", 2'b01, 2'b01, 3'd0, 1'b1, 1'b0);
        // activity during RECOVER: prediction ignored, resolve flags err
        cyc(1, 1, 1, 1); chk_state("rec", 2'b01, 2'b01, 3'd0, 1'b0, 1'b1);
        chk("rec_err", 32'(err), 32'd1);

        // resolve on empty FIFO, then push + correct resolve at inflight=2
        do_reset();
        chk("e_err0", 32'(err), 32'd0);
        cyc(0, 0, 1, 1); chk_state("e", 2'b00, 2'b00, 3'd0, 1'b0, 1'b1);
        chk("e_err1", 32'(err), 32'd1);
        cyc(0, 0, 0, 0); chk("e_err2", 32'(err), 32'd1);
        cyc(1, 1, 0, 0);
        cyc(1, 0, 0, 0); chk_state("pr_pre", 2'b01, 2'b00, 3'd2, 1'b0, 1'b1);
        cyc(1, 1, 1, 1); chk_state("pr", 2'b10, 2'b10, 3'd2, 1'b0, 1'b1);
        chk("pr_err", 32'(err), 32'd1);

        // asynchronous reset mid-cycle
        do_reset();
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(1, 0, 0, 0); chk_state("ar_pre", 2'b01, 2'b00, 3'd3, 1'b0, 1'b1);
        #2;
        rstn = 1'b0;
        #1;
        chk_state("ar", 2'b00, 2'b00, 3'd0, 1'b0, 1'b1);
        chk("ar_err", 32'(err), 32'd0);
        rstn = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
